// File: rtl/sa_enable_sequencer.sv
// -----------------------------------------------------------------------------
// sa_enable_sequencer
//
// Purpose:
//   Control-side driver for the systolic-array enable decode path. A start
//   request launches a frame that walks the step counter from 0 up to
//   LAST_STEP. For each step the block presents the reference 3-bit PE-row
//   enable pattern. Frames can be stalled or aborted, and the block reports
//   its progress with a start/busy/done handshake.
//
// Parameters:
//   CNT_W      width of the step counter and the cnt port (default 4)
//   LAST_STEP  final step index of a frame, legal range 1..8 (default 8)
//
// Ports:
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   start       in   frame request; only looked at while idle
//   stall       in   hold the current step; en forced to 000 while high
//   abort       in   synchronous abort back to idle; no done pulse
//   cnt         out  current step index (registered)
//   en          out  PE-row enable for the current step
//   step_valid  out  en carries a live step (running and not stalled)
//   busy        out  frame in progress
//   done        out  one-cycle pulse after the last step completes
//   frame_cnt   out  [7:0] completed-frame counter, wraps 255->0
//                    (present only when SA_SEQ_FRAME_CNT_EN is defined)
//
// Build option:
//   SA_SEQ_FRAME_CNT_EN  adds the frame_cnt output and its counter.
// -----------------------------------------------------------------------------
module sa_enable_sequencer #(
    parameter int CNT_W     = 4,
    parameter int LAST_STEP = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stall,
    input  logic             abort,
    output logic [CNT_W-1:0] cnt,
    output logic [2:0]       en,
    output logic             step_valid,
    output logic             busy,
`ifdef SA_SEQ_FRAME_CNT_EN
    output logic             done,
    output logic [7:0]       frame_cnt
`else
    output logic             done
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LAST_STEP);

    state_t state;

    // Fixed per-step enable pattern. Indices past the table give no enables.
    function automatic logic [2:0] en_lookup(input logic [CNT_W-1:0] idx);
        int unsigned i;
        logic [2:0]  pat;
        i = 32'(idx);
        case (i)
            0:       pat = 3'b111;
            1:       pat = 3'b101;
            2:       pat = 3'b010;
            3:       pat = 3'b100;
            4:       pat = 3'b010;
            5:       pat = 3'b001;
            6:       pat = 3'b110;
            7:       pat = 3'b001;
            8:       pat = 3'b111;
            default: pat = 3'b000;
        endcase
        return pat;
    endfunction

    // busy and done are registered together with the state. This keeps them
    // exactly aligned with it and glitch-free toward the top-level controller.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (abort) begin
            // abort outranks start and stall and never produces done
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        if (cnt == LAST_IDX) begin
                            state <= DONE;
                            cnt   <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    // start is not queued here; it is only seen back in IDLE
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // stall gates en in the same cycle, so the array never sees a step twice
    always_comb begin
        step_valid = (state == RUN) && !stall;
        en         = step_valid ? en_lookup(cnt) : 3'b000;
    end

`ifdef SA_SEQ_FRAME_CNT_EN
    // Counts completed frames only; an aborted frame never reaches DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt <= 8'd0;
        end else if (done) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sa_enable_sequencer.sv
module tb_sa_enable_sequencer;

    localparam int LAST = 8;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       start   = 1'b0;
    logic       stall   = 1'b0;
    logic       abort   = 1'b0;
    logic [3:0] cnt;
    logic [2:0] en;
    logic       step_valid;
    logic       busy;
    logic       done;
`ifdef SA_SEQ_FRAME_CNT_EN
    logic [7:0] frame_cnt;
    logic [7:0] fc_before;
`endif

    sa_enable_sequencer #(
        .CNT_W     (4),
        .LAST_STEP (LAST)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .stall      (stall),
        .abort      (abort),
        .cnt        (cnt),
        .en         (en),
        .step_valid (step_valid),
        .busy       (busy),
`ifdef SA_SEQ_FRAME_CNT_EN
        .done       (done),
        .frame_cnt  (frame_cnt)
`else
        .done       (done)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_done;
        int cyc;
        int cnt;
        int en;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // hand-written reference enable table
    logic [2:0] en_tab [0:8] = '{3'b111, 3'b101, 3'b010, 3'b100, 3'b010,
                                 3'b001, 3'b110, 3'b001, 3'b111};

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic push_step(int c, int idx);
        exp_t e;
        e.is_done = 1'b0;
        e.cyc     = c;
        e.cnt     = idx;
        e.en      = int'(en_tab[idx]);
        q.push_back(e);
    endtask

    task automatic push_done(int c);
        exp_t e;
        e.is_done = 1'b1;
        e.cyc     = c;
        e.cnt     = 0;
        e.en      = 0;
        q.push_back(e);
    endtask

    // start seen at the edge after cycle `base`: steps follow, then done
    task automatic push_frame(int base);
        for (int i = 0; i <= LAST; i++) push_step(base + 1 + i, i);
        push_done(base + LAST + 2);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(int budget);
        int k;
        k = 0;
        while (q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        chk("drain_pending", q.size(), 0);
    endtask

    task automatic chk_idle(string tag);
        chk({tag, "_cnt"},   cnt, 0);
        chk({tag, "_en"},    en, 0);
        chk({tag, "_valid"}, step_valid, 0);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
    endtask

    // Monitor: every presented step or done pulse is matched to the scoreboard
    always @(negedge clk) begin
        if (reset_n && (step_valid || done)) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output got cnt %0d en %0d done %0b expected nothing (cycle %0d)",
                         cnt, en, done, cyc);
            end else begin
                mon_e = q.pop_front();
                chk("out_kind", done, mon_e.is_done);
                chk("out_cycle", cyc, mon_e.cyc);
                if (!mon_e.is_done) begin
                    chk("out_cnt", cnt, mon_e.cnt);
                    chk("out_en", en, mon_e.en);
                    chk("busy_in_step", busy, 1);
                end else begin
                    chk("busy_in_done", busy, 0);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // reset values
        repeat (2) tick();
        chk_idle("reset");
`ifdef SA_SEQ_FRAME_CNT_EN
        chk("reset_frame_cnt", frame_cnt, 0);
`endif
        reset_n = 1'b1;
        tick();

        // plain frame
        n = cyc;
        start = 1'b1;
        push_frame(n);
        tick();
        start = 1'b0;
        wait_drain(40);
        tick();
        chk_idle("after_frame");

        // stall two cycles while cnt=3
        n = cyc;
        start = 1'b1;
        for (int i = 0; i <= 2; i++) push_step(n + 1 + i, i);
        push_step(n + 6, 3);
        for (int i = 4; i <= LAST; i++) push_step(n + 3 + i, i);
        push_done(n + 12);
        tick();
        start = 1'b0;
        while (cyc < n + 4) tick();
        stall = 1'b1;
        #1;
        chk("stall_cnt", cnt, 3);
        chk("stall_en", en, 0);
        chk("stall_valid", step_valid, 0);
        chk("stall_busy", busy, 1);
        tick();
        chk("stall_hold_cnt", cnt, 3);
        chk("stall_hold_en", en, 0);
        tick();
        stall = 1'b0;
        #1;
        chk("resume_en", en, 3'b100);
        wait_drain(40);
        tick();

        // abort at cnt=5
`ifdef SA_SEQ_FRAME_CNT_EN
        fc_before = frame_cnt;
`endif
        n = cyc;
        start = 1'b1;
        for (int i = 0; i <= 5; i++) push_step(n + 1 + i, i);
        tick();
        start = 1'b0;
        while (cyc < n + 6) tick();
        chk("abort_pre_cnt", cnt, 5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_idle("abort");
        repeat (12) tick();
        chk("abort_leftover", q.size(), 0);
`ifdef SA_SEQ_FRAME_CNT_EN
        chk("abort_frame_cnt", frame_cnt, fc_before);
`endif

        // start held high: restart only from idle, period 11
        n = cyc;
        start = 1'b1;
        push_frame(n);
        push_frame(n + 11);
        while (cyc < n + 16) tick();
        start = 1'b0;
        wait_drain(40);
        repeat (3) tick();
        chk_idle("held_start_end");

        // asynchronous reset mid-frame at cnt=6
        n = cyc;
        start = 1'b1;
        for (int i = 0; i <= 5; i++) push_step(n + 1 + i, i);
        tick();
        start = 1'b0;
        while (cyc < n + 7) tick();
        chk("areset_pre_cnt", cnt, 6);
        #2;
        reset_n = 1'b0;
        #1;
        chk_idle("areset");
`ifdef SA_SEQ_FRAME_CNT_EN
        chk("areset_frame_cnt", frame_cnt, 0);
`endif
        tick();
        reset_n = 1'b1;
        tick();
        chk_idle("areset_release");
        n = cyc;
        start = 1'b1;
        push_frame(n);
        tick();
        start = 1'b0;
        wait_drain(40);
        tick();
        chk_idle("areset_clean_frame");

`ifdef SA_SEQ_FRAME_CNT_EN
        chk("frame_cnt_one", frame_cnt, 1);
        // 256 more frames: 257 completed since reset -> wraps to 1
        n = cyc;
        start = 1'b1;
        for (int f = 0; f < 256; f++) push_frame(n + 11 * f);
        while (cyc < n + 11 * 255 + 3) tick();
        start = 1'b0;
        wait_drain(60);
        tick();
        chk("frame_cnt_wrap", frame_cnt, 1);
`endif

        repeat (4) tick();
        chk("queue_empty_end", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
